// File: rtl/rename_reg_file_if.sv
// Decoder/ROB-side bus of the rename register file: commit, rename,
// flush, two source-register read ports and the ROB forwarding query.
interface rename_reg_file_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  // flush and commit/rename requests
  logic                     clear;
  logic [4:0]               set_reg_id;
  logic [31:0]              set_val;
  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id;
  logic [4:0]               set_dep_reg_id;
  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id;

  // source read ports
  logic [4:0]               rs1_id;
  logic [4:0]               rs2_id;
  logic                     rs1_ready;
  logic                     rs2_ready;
  logic [31:0]              rs1_val;
  logic [31:0]              rs2_val;
  logic [ROB_WIDTH_BIT-1:0] rs1_rob_id;
  logic [ROB_WIDTH_BIT-1:0] rs2_rob_id;

  // ROB forwarding query
  logic [ROB_WIDTH_BIT-1:0] get_rob_id1;
  logic [ROB_WIDTH_BIT-1:0] get_rob_id2;
  logic                     rob_value1_ready;
  logic                     rob_value2_ready;
  logic [31:0]              rob_value1;
  logic [31:0]              rob_value2;

  // decoder/ROB side
  modport master (
    output clear, set_reg_id, set_val, set_reg_on_rob_id,
           set_dep_reg_id, set_dep_rob_id, rs1_id, rs2_id,
           rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    input  rs1_ready, rs2_ready, rs1_val, rs2_val, rs1_rob_id, rs2_rob_id,
           get_rob_id1, get_rob_id2
  );

  // register file side
  modport slave (
    input  clear, set_reg_id, set_val, set_reg_on_rob_id,
           set_dep_reg_id, set_dep_rob_id, rs1_id, rs2_id,
           rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    output rs1_ready, rs2_ready, rs1_val, rs2_val, rs1_rob_id, rs2_rob_id,
           get_rob_id1, get_rob_id2
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tracking: 32 x 32-bit values,
// a busy bit and producing ROB tag per register. Reads are combinational
// and resolve through commit bypass and ROB forwarding.
module rename_reg_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  rename_reg_file_if.slave   bus
);

  typedef logic [ROB_WIDTH_BIT-1:0] tag_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] val;
    tag_t        rob_id;
    tag_t        get_id;
  } port_t;

  logic [31:0] value_q [32];
  logic [31:0] busy_q;
  tag_t        dep_q   [32];

  logic commit_en;
  logic rename_en;
  logic commit_tag_hit;

  assign commit_en      = rdy_in && (bus.set_reg_id != 5'd0);
  assign rename_en      = rdy_in && !bus.clear && (bus.set_dep_reg_id != 5'd0);
  assign commit_tag_hit = (dep_q[bus.set_reg_id] == bus.set_reg_on_rob_id);

  // Register state update: reset, value commit, busy clear, rename.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      value_q <= '{default: '0};
      dep_q   <= '{default: '0};
      busy_q  <= '0;
    end else if (rdy_in) begin
      if (commit_en) begin
        value_q[bus.set_reg_id] <= bus.set_val;
      end
      if (bus.clear) begin
        busy_q <= '0;
      end else begin
        if (commit_en && commit_tag_hit) begin
          busy_q[bus.set_reg_id] <= 1'b0;
        end
        // Placed after the commit clear so a same-register rename wins.
        if (rename_en) begin
          busy_q[bus.set_dep_reg_id] <= 1'b1;
          dep_q[bus.set_dep_reg_id]  <= bus.set_dep_rob_id;
        end
      end
    end
  end

  // Resolve one source read from pre-update state.
  function automatic port_t read_port(
    input logic [4:0]  id,
    input logic        busy,
    input logic [31:0] val,
    input tag_t        dep,
    input logic        commit_hit,
    input logic [31:0] commit_val,
    input logic        rob_ready,
    input logic [31:0] rob_val
  );
    port_t r;
    r = '0;
    if (id == 5'd0) begin
      r.ready = 1'b1;
    end else if (!busy) begin
      r.ready = 1'b1;
      r.val   = val;
    end else begin
      r.get_id = dep;
      if (commit_hit) begin
        r.ready = 1'b1;
        r.val   = commit_val;
      end else if (rob_ready) begin
        r.ready = 1'b1;
        r.val   = rob_val;
      end else begin
        r.rob_id = dep;
      end
    end
    return r;
  endfunction

  logic  hit1;
  logic  hit2;
  port_t p1;
  port_t p2;

  assign hit1 = commit_en && (bus.set_reg_id == bus.rs1_id) &&
                (bus.set_reg_on_rob_id == dep_q[bus.rs1_id]);
  assign hit2 = commit_en && (bus.set_reg_id == bus.rs2_id) &&
                (bus.set_reg_on_rob_id == dep_q[bus.rs2_id]);

  // Source port 1 lookup.
  always_comb begin
    p1 = read_port(bus.rs1_id, busy_q[bus.rs1_id], value_q[bus.rs1_id],
                   dep_q[bus.rs1_id], hit1, bus.set_val,
                   bus.rob_value1_ready, bus.rob_value1);
  end

  // Source port 2 lookup.
  always_comb begin
    p2 = read_port(bus.rs2_id, busy_q[bus.rs2_id], value_q[bus.rs2_id],
                   dep_q[bus.rs2_id], hit2, bus.set_val,
                   bus.rob_value2_ready, bus.rob_value2);
  end

  assign bus.rs1_ready   = p1.ready;
  assign bus.rs1_val     = p1.val;
  assign bus.rs1_rob_id  = p1.rob_id;
  assign bus.get_rob_id1 = p1.get_id;
  assign bus.rs2_ready   = p2.ready;
  assign bus.rs2_val     = p2.val;
  assign bus.rs2_rob_id  = p2.rob_id;
  assign bus.get_rob_id2 = p2.get_id;

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rename_reg_file;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  int tests = 0;
  int fails = 0;

  rename_reg_file_if #(.ROB_WIDTH_BIT(RW)) bus ();

  rename_reg_file #(.ROB_WIDTH_BIT(RW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_dep  [32];
  bit            model_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b1;
    rdy = 1'b1;
    bus.clear = 1'b0;
    bus.set_reg_id = '0;
    bus.set_val = '0;
    bus.set_reg_on_rob_id = '0;
    bus.set_dep_reg_id = '0;
    bus.set_dep_rob_id = '0;
    bus.rs1_id = '0;
    bus.rs2_id = '0;
    bus.rob_value1_ready = 1'b0;
    bus.rob_value2_ready = 1'b0;
    bus.rob_value1 = '0;
    bus.rob_value2 = '0;
  endtask

  task automatic model_read(input logic [4:0] id, input logic rr, input logic [31:0] rv,
                            output logic e_ready, output logic [31:0] e_val,
                            output logic [RW-1:0] e_rob, output logic [RW-1:0] e_get);
    e_ready = 1'b1; e_val = 0; e_rob = 0; e_get = 0;
    if (id != 0 && m_busy[id]) begin
      e_get = m_dep[id];
      if (rdy && bus.set_reg_id == id && bus.set_reg_on_rob_id == m_dep[id])
        e_val = bus.set_val;
      else if (rr)
        e_val = rv;
      else begin
        e_ready = 1'b0;
        e_rob = m_dep[id];
      end
    end else if (id != 0) begin
      e_val = m_val[id];
    end
  endtask

  task automatic compare_model();
    logic e_r; logic [31:0] e_v; logic [RW-1:0] e_rob; logic [RW-1:0] e_get;
    if (!model_valid) return;
    model_read(bus.rs1_id, bus.rob_value1_ready, bus.rob_value1, e_r, e_v, e_rob, e_get);
    check("rs1_ready", 32'(bus.rs1_ready), 32'(e_r));
    check("rs1_val", bus.rs1_val, e_v);
    check("rs1_rob_id", 32'(bus.rs1_rob_id), 32'(e_rob));
    check("get_rob_id1", 32'(bus.get_rob_id1), 32'(e_get));
    model_read(bus.rs2_id, bus.rob_value2_ready, bus.rob_value2, e_r, e_v, e_rob, e_get);
    check("rs2_ready", 32'(bus.rs2_ready), 32'(e_r));
    check("rs2_val", bus.rs2_val, e_v);
    check("rs2_rob_id", 32'(bus.rs2_rob_id), 32'(e_rob));
    check("get_rob_id2", 32'(bus.get_rob_id2), 32'(e_get));
  endtask

  task automatic model_update();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_dep[i] = 0;
      end
      model_valid = 1;
    end else if (rdy) begin
      if (bus.set_reg_id != 0) m_val[bus.set_reg_id] = bus.set_val;
      if (bus.clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (bus.set_reg_id != 0 && m_dep[bus.set_reg_id] == bus.set_reg_on_rob_id)
          m_busy[bus.set_reg_id] = 0;
        if (bus.set_dep_reg_id != 0) begin
          m_busy[bus.set_dep_reg_id] = 1;
          m_dep[bus.set_dep_reg_id] = bus.set_dep_rob_id;
        end
      end
    end
  endtask

  // settle, check against model, clock once, advance model, return at negedge
  task automatic cycle();
    #1;
    compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    idle();
    // reset
    rst = 1'b0;
    cycle();
    idle();
    bus.rs1_id = 5; bus.rs2_id = 7;
    #1;
    check("rst_rs1_ready", 32'(bus.rs1_ready), 32'd1);
    check("rst_rs1_val", bus.rs1_val, 32'd0);
    check("rst_rs2_rob", 32'(bus.rs2_rob_id), 32'd0);
    check("rst_get2", 32'(bus.get_rob_id2), 32'd0);
    cycle();

    // commit to a non-busy register
    idle(); bus.set_reg_id = 5; bus.set_val = 32'h1234; bus.set_reg_on_rob_id = 3;
    cycle();
    idle(); bus.rs1_id = 5;
    #1;
    check("commit_ready", 32'(bus.rs1_ready), 32'd1);
    check("commit_val", bus.rs1_val, 32'h1234);
    cycle();

    // rename then ROB forwarding
    idle(); bus.set_dep_reg_id = 7; bus.set_dep_rob_id = 9;
    cycle();
    idle(); bus.rs2_id = 7;
    #1;
    check("ren_ready", 32'(bus.rs2_ready), 32'd0);
    check("ren_rob_id", 32'(bus.rs2_rob_id), 32'd9);
    check("ren_get2", 32'(bus.get_rob_id2), 32'd9);
    bus.rob_value2_ready = 1'b1; bus.rob_value2 = 32'hAB;
    #1;
    check("fwd_ready", 32'(bus.rs2_ready), 32'd1);
    check("fwd_val", bus.rs2_val, 32'hAB);
    check("fwd_rob_id", 32'(bus.rs2_rob_id), 32'd0);
    cycle();

    // stale-tag commit keeps the newer producer
    idle(); bus.set_dep_reg_id = 7; bus.set_dep_rob_id = 10;
    cycle();
    idle(); bus.set_reg_id = 7; bus.set_val = 5; bus.set_reg_on_rob_id = 9;
    cycle();
    idle(); bus.rs1_id = 7;
    #1;
    check("stale_ready", 32'(bus.rs1_ready), 32'd0);
    check("stale_rob_id", 32'(bus.rs1_rob_id), 32'd10);
    bus.set_reg_id = 7; bus.set_val = 32'h77; bus.set_reg_on_rob_id = 10;
    #1;
    check("bypass_ready", 32'(bus.rs1_ready), 32'd1);
    check("bypass_val", bus.rs1_val, 32'h77);
    cycle();
    idle(); bus.rs1_id = 7;
    #1;
    check("match_ready", 32'(bus.rs1_ready), 32'd1);
    check("match_val", bus.rs1_val, 32'h77);
    cycle();

    // same-cycle commit and rename of x4
    idle(); bus.set_dep_reg_id = 4; bus.set_dep_rob_id = 2;
    cycle();
    idle(); bus.set_reg_id = 4; bus.set_val = 32'h44; bus.set_reg_on_rob_id = 2;
    bus.set_dep_reg_id = 4; bus.set_dep_rob_id = 6; bus.rs1_id = 4;
    #1;
    check("same_bypass_ready", 32'(bus.rs1_ready), 32'd1);
    check("same_bypass_val", bus.rs1_val, 32'h44);
    cycle();
    idle(); bus.rs1_id = 4;
    #1;
    check("same_busy", 32'(bus.rs1_ready), 32'd0);
    check("same_dep", 32'(bus.rs1_rob_id), 32'd6);
    cycle();

    // commit x1..x3, rename them, flush
    for (int i = 1; i <= 3; i++) begin
      idle(); bus.set_reg_id = 5'(i); bus.set_val = 32'(i * 'h11); bus.set_reg_on_rob_id = 0;
      cycle();
    end
    for (int i = 1; i <= 3; i++) begin
      idle(); bus.set_dep_reg_id = 5'(i); bus.set_dep_rob_id = RW'(i);
      cycle();
    end
    idle(); bus.rs1_id = 1;
    #1;
    check("pre_clear_busy", 32'(bus.rs1_ready), 32'd0);
    bus.clear = 1'b1; bus.set_dep_reg_id = 5; bus.set_dep_rob_id = 7;
    cycle();
    idle(); bus.rs1_id = 1; bus.rs2_id = 5;
    #1;
    check("clr_rs1_ready", 32'(bus.rs1_ready), 32'd1);
    check("clr_rs1_val", bus.rs1_val, 32'h11);
    check("clr_ignored_ren", 32'(bus.rs2_ready), 32'd1);
    check("clr_x5_val", bus.rs2_val, 32'h1234);
    bus.rs1_id = 4; bus.rs2_id = 3;
    #1;
    check("clr_x4_val", bus.rs1_val, 32'h44);
    check("clr_x3_val", bus.rs2_val, 32'h33);
    cycle();

    // stall holds state
    idle(); rdy = 1'b0; bus.set_reg_id = 6; bus.set_val = 32'h99;
    bus.set_dep_reg_id = 6; bus.set_dep_rob_id = 4;
    cycle();
    idle(); bus.rs1_id = 6;
    #1;
    check("stall_ready", 32'(bus.rs1_ready), 32'd1);
    check("stall_val", bus.rs1_val, 32'd0);
    cycle();

    // reset mid-stream
    idle(); bus.set_dep_reg_id = 8; bus.set_dep_rob_id = 5;
    cycle();
    idle(); rst = 1'b0; bus.set_reg_id = 9; bus.set_val = 32'h5; bus.set_dep_reg_id = 9;
    cycle();
    idle(); bus.rs1_id = 8; bus.rs2_id = 5;
    #1;
    check("mid_rst_ready", 32'(bus.rs1_ready), 32'd1);
    check("mid_rst_get1", 32'(bus.get_rob_id1), 32'd0);
    check("mid_rst_rob1", 32'(bus.rs1_rob_id), 32'd0);
    check("mid_rst_val2", bus.rs2_val, 32'd0);
    cycle();

    // randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      bus.clear = ($urandom_range(0, 15) == 0);
      bus.set_reg_id = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      bus.set_val = $urandom;
      bus.set_reg_on_rob_id = RW'($urandom_range(0, 15));
      bus.set_dep_reg_id = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      bus.set_dep_rob_id = RW'($urandom_range(0, 15));
      bus.rs1_id = 5'($urandom_range(0, 8));
      bus.rs2_id = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
      bus.rob_value1_ready = ($urandom_range(0, 2) == 0);
      bus.rob_value2_ready = ($urandom_range(0, 2) == 0);
      bus.rob_value1 = $urandom;
      bus.rob_value2 = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 The module SHALL take parameter ROB_WIDTH_BIT, default 4, giving the ROB tag width (16 in-flight tags).
REQ-002 clk_in  input  1  the single system clock; all state SHALL change only on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-low; asserted when 0, sampled on the clk_in rising edge.
REQ-004 rdy_in  input  1  global ready; while 0, state SHALL hold.
REQ-005 clear  input  1  misprediction flush from the ROB.
REQ-006 set_reg_id  input  5  commit destination register; 0 means no commit.
REQ-007 set_val  input  32  commit value.
REQ-008 set_reg_on_rob_id  input  ROB_WIDTH_BIT  ROB tag of the committing entry.
REQ-009 set_dep_reg_id  input  5  rename destination register; 0 means no rename.
REQ-010 set_dep_rob_id  input  ROB_WIDTH_BIT  ROB tag allocated for the rename.
REQ-011 rs1_id, rs2_id  input  5  source registers read by the decoder.
REQ-012 rs1_ready, rs2_ready  output  1  source value is available this cycle.
REQ-013 rs1_val, rs2_val  output  32  source value; valid when ready = 1, otherwise 0.
REQ-014 rs1_rob_id, rs2_rob_id  output  ROB_WIDTH_BIT  producing ROB tag when ready = 0, otherwise 0.
REQ-015 get_rob_id1, get_rob_id2  output  ROB_WIDTH_BIT  ROB forwarding query tag; equals the dependency tag of rs1/rs2, otherwise 0.
REQ-016 rob_value1_ready, rob_value2_ready  input  1  the ROB holds a finished result for the queried tag.
REQ-017 rob_value1, rob_value2  input  32  forwarded ROB value.

Function
REQ-018 State SHALL be 32 x 32-bit values, 32 busy bits and 32 x ROB_WIDTH_BIT dependency tags; register x0 SHALL read 0, never be busy and never be written.
REQ-019 Commit: when rdy_in=1 and set_reg_id!=0, value[set_reg_id] SHALL become set_val at the next edge.
REQ-020 Commit clears busy[set_reg_id] only if dep[set_reg_id]==set_reg_on_rob_id; on a tag mismatch busy and dep SHALL remain unchanged.
REQ-021 Rename: when rdy_in=1, clear=0 and set_dep_reg_id!=0, busy SHALL become 1 and dep SHALL become set_dep_rob_id at the next edge.
REQ-022 A rename and a commit to the same register in the same cycle: the value SHALL be written, and the rename SHALL win for busy and dep.
REQ-023 clear=1 (with rdy_in=1): all busy bits SHALL be cleared and renames ignored; a commit in the same cycle SHALL still write its value.
REQ-024 rdy_in=0: no value, busy or dep SHALL change; reads remain combinational.
REQ-025 Read priority per port, purely combinational (zero latency):
  - id==0: ready=1, val=0.
  - Not busy: ready=1, val=value[id].
  - Busy and a same-cycle commit to id with a matching tag: ready=1, val=set_val.
  - Busy and rob_valueN_ready=1: ready=1, val=rob_valueN.
  - Otherwise: ready=0, rob_id=dep[id].
REQ-026 Reads SHALL observe state before any same-cycle rename, so an instruction with rs==rd gets its old producer.
REQ-027 Tags SHALL be compared at full ROB_WIDTH_BIT width; wrap-around of tag numbers needs no special handling.

Reset
REQ-028 With rst_in=0 at an edge, all values, busy bits and dep tags SHALL become 0; reset overrides clear, commit and rename.
REQ-029 After reset, every read port SHALL return ready=1, val=0 and rob_id=0, and get_rob_id1/2 SHALL be 0.

Verification
REQ-030 Reset, then commit x5=0x1234 (tag 3, not busy) -> next cycle rs1_id=5 gives ready=1, val=0x1234.
REQ-031 Rename x7->tag 9, then read rs2_id=7 with rob_value2_ready=0 -> ready=0, rs2_rob_id=9, get_rob_id2=9; set rob_value2_ready=1, rob_value2=0xAB -> ready=1, val=0xAB.
REQ-032 Rename x7->tag 9, then x7->tag 10, then commit x7 with tag 9 value 5 -> value=5, still busy, dep=10; commit with tag 10 -> not busy.
REQ-033 Same cycle: commit x4 with tag 2 (matching) and rename x4->tag 6 -> x4 busy, dep=6, value updated; a same-cycle read of x4 returns the bypassed commit value.
REQ-034 Rename x1..x3, then pulse clear -> all ready=1 with the old committed values; a rename in the clear cycle is ignored.
REQ-035 Hold rdy_in=0 with commit and rename active -> no state change; rst_in=0 mid-stream -> all zero next cycle.
